// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice.
// The controller state enum lives here so the controller and any
// future display or debug logic agree on one encoding.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/stopwatch_tick_prescaler.sv
// Divides clk down to one tick every TICK_DIV cycles while running.
// The count holds its phase when run drops, so a paused stopwatch
// resumes mid-tick instead of restarting the tick period.
module tick_prescaler #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic zero,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  assign tick = run && (count == LAST);

  // Count 0..TICK_DIV-1 while running, hold otherwise, zero on request
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (zero) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/halt controller driving an external digit counter chain.
// Lap (display freeze) support is compiled in only when STOPWATCH_LAP_EN is
// defined; without it the display_hold port is kept and tied low.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV    = 10_000_000,
  parameter int STOP_AT_MAX = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_stop,
  input  logic clear,
  input  logic lap,
  input  logic chain_max,
  output logic count_en,
  output logic count_clr,
  output logic running,
  output logic overflow,
  output logic display_hold
);

  state_t state;
  state_t next_state;
  logic   tick;
  logic   max_hit;
  logic   clr_pending;
  logic   stop_en;

  assign stop_en = (STOP_AT_MAX != 0);
  assign max_hit = tick && stop_en && chain_max;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state == RUN),
    .zero    ((state == IDLE) || (state == HALT)),
    .tick    (tick)
  );

  // State register plus the one-cycle-delayed clear strobe for the chain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      clr_pending <= 1'b0;
    end else begin
      state       <= next_state;
      clr_pending <= clear;
    end
  end

  // Next state: clear beats saturation, saturation beats start_stop
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else if (max_hit) begin
      next_state = HALT;
    end else if (start_stop) begin
      case (state)
        IDLE:    next_state = RUN;
        RUN:     next_state = PAUSE;
        PAUSE:   next_state = RUN;
        HALT:    next_state = HALT;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs: a tick that would push the chain past its maximum is swallowed
  always_comb begin
    count_en  = tick && !max_hit;
    count_clr = clr_pending;
    running   = (state == RUN);
    overflow  = (state == HALT);
  end

`ifdef STOPWATCH_LAP_EN
  logic hold;

  // Lap freezes or releases the display only while time is being kept
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold <= 1'b0;
    end else if (clear) begin
      hold <= 1'b0;
    end else if (lap && ((state == RUN) || (state == PAUSE))) begin
      hold <= ~hold;
    end
  end

  assign display_hold = hold;
`else
  logic unused_lap;

  assign unused_lap   = lap;
  assign display_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (TICK_DIV=4, STOP_AT_MAX=1).
// A behavioural model tracks run time as an unbounded cycle count and
// derives ticks from it arithmetically; directed scenarios are followed
// by a long randomized run checked cycle by cycle against the model.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;
  logic chain_max = 1'b0;
  logic count_en, count_clr, running, overflow, display_hold;

  int numChecks = 0;
  int numFails = 0;

  // Reference model: what the stopwatch is doing, not how the RTL encodes it
  bit mIdle, mRun, mHalt;
  bit mHold, mClrPend;
  int mRunCycles;

  // Observed outputs from the most recent cycle, for directed checks
  logic obsCountEn, obsCountClr, obsRunning, obsOverflow, obsHold;
  int tickCycles[$];

  stopwatch_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .STOP_AT_MAX (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_stop   (start_stop),
    .clear        (clear),
    .lap          (lap),
    .chain_max    (chain_max),
    .count_en     (count_en),
    .count_clr    (count_clr),
    .running      (running),
    .overflow     (overflow),
    .display_hold (display_hold)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mIdle = 1'b1; mRun = 1'b0; mHalt = 1'b0;
    mHold = 1'b0; mClrPend = 1'b0; mRunCycles = 0;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance the model at the edge
  task automatic applyStimulus(bit ss, bit clr, bit lp, bit cm, bit rn);
    bit mTick;
    bit mPause;
    start_stop = ss; clear = clr; lap = lp; chain_max = cm; reset_n = rn;
    @(negedge clk);
    mPause = !mIdle && !mRun && !mHalt;
    mTick = mRun && ((mRunCycles % TICK_DIV) == TICK_DIV - 1);
    checkOutput("running", running, mRun);
    checkOutput("overflow", overflow, mHalt);
    checkOutput("count_clr", count_clr, mClrPend);
    checkOutput("count_en", count_en, mTick && !cm);
    checkOutput("display_hold", display_hold, LAP_ON && mHold);
    obsCountEn = count_en; obsCountClr = count_clr; obsRunning = running;
    obsOverflow = overflow; obsHold = display_hold;
    @(posedge clk);
    if (!rn) begin
      modelReset();
    end else begin
      mClrPend = clr;
      if (clr) mHold = 1'b0;
      else if (lp && (mRun || mPause)) mHold = !mHold;
      if (mIdle || mHalt) mRunCycles = 0;
      else if (mRun) mRunCycles++;
      if (clr) begin
        mIdle = 1'b1; mRun = 1'b0; mHalt = 1'b0;
      end else if (mTick && cm) begin
        mIdle = 1'b0; mRun = 1'b0; mHalt = 1'b1;
      end else if (ss && !mHalt) begin
        mRun = !mRun; mIdle = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // Reset state
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("reset_running", obsRunning, 0);
    checkOutput("reset_count_clr", obsCountClr, 0);

    // Free running ticks every TICK_DIV cycles
    tickCycles.delete();
    for (int c = 0; c <= 12; c++) begin
      applyStimulus(c == 0, 0, 0, 0, 1);
      if (obsCountEn) tickCycles.push_back(c);
    end
    checkOutput("run_tick_count", tickCycles.size(), 3);
    checkOutput("run_tick0", tickCycles[0], 4);
    checkOutput("run_tick1", tickCycles[1], 8);
    checkOutput("run_tick2", tickCycles[2], 12);
    checkOutput("run_running", obsRunning, 1);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Pause keeps the prescaler phase
    tickCycles.delete();
    for (int c = 0; c <= 22; c++) begin
      applyStimulus(c == 0 || c == 6 || c == 20, 0, 0, 0, 1);
      if (obsCountEn) tickCycles.push_back(c);
    end
    checkOutput("pause_tick_count", tickCycles.size(), 2);
    checkOutput("pause_tick0", tickCycles[0], 4);
    checkOutput("pause_resume_tick", tickCycles[1], 22);

    // Clear beats start_stop in the same cycle
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clr_pulse", obsCountClr, 1);
    checkOutput("clr_running", obsRunning, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clr_pulse_end", obsCountClr, 0);

    // Chain saturation halts the stopwatch
    for (int c = 0; c <= 4; c++) applyStimulus(c == 0, 0, 0, c == 4, 1);
    checkOutput("max_count_en", obsCountEn, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("max_overflow", obsOverflow, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("halt_ignores_ss", obsOverflow, 1);
    checkOutput("halt_running", obsRunning, 0);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("halt_cleared", obsOverflow, 0);
    checkOutput("halt_clr_pulse", obsCountClr, 1);

    // Lap freezes the display while counting continues
    tickCycles.delete();
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(c == 0, 0, c == 2 || c == 5, 0, 1);
      if (obsCountEn) tickCycles.push_back(c);
      if (c == 3) checkOutput("lap_hold_on", obsHold, LAP_ON);
      if (c == 6) checkOutput("lap_hold_off", obsHold, 0);
    end
    checkOutput("lap_tick", tickCycles[0], 4);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Reset mid-run loses the prescaler phase
    tickCycles.delete();
    for (int c = 0; c <= 9; c++) begin
      applyStimulus(c == 0 || c == 4, 0, 0, 0, c != 3);
      if (obsCountEn) tickCycles.push_back(c);
      if (c == 4) begin
        checkOutput("rst_running", obsRunning, 0);
        checkOutput("rst_count_en", obsCountEn, 0);
        checkOutput("rst_overflow", obsOverflow, 0);
      end
    end
    checkOutput("rst_tick_count", tickCycles.size(), 1);
    checkOutput("rst_first_tick", tickCycles[0], 8);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 150) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter: TICK_DIV, default 10_000_000, clk cycles per count tick (>=2).
REQ-002 SHALL have parameter: STOP_AT_MAX, default 1; 1 = halt at chain maximum, 0 = let chain wrap.
REQ-003 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port: start_stop  input  1  single-cycle pulse, toggles run/pause.
REQ-006 SHALL have port: clear  input  1  single-cycle pulse, return to zero.
REQ-007 SHALL have port: lap  input  1  single-cycle pulse, toggles display freeze.
REQ-008 SHALL have port: chain_max  input  1  counter chain at terminal value on all digits, ungated by enable.
REQ-009 SHALL have port: count_en  output  1  one-cycle enable to the counter chain.
REQ-010 SHALL have port: count_clr  output  1  one-cycle synchronous clear to the counter chain.
REQ-011 SHALL have port: running  output  1  high in RUN.
REQ-012 SHALL have port: overflow  output  1  sticky, high in HALT.
REQ-013 SHALL have port: display_hold  output  1  freeze display registers (lap).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, HALT.
REQ-015 SHALL transition IDLE->RUN, RUN->PAUSE and PAUSE->RUN on start_stop; start_stop SHALL be ignored in HALT.
REQ-016 SHALL, on clear in any state, go to IDLE next cycle and assert count_clr for exactly the following cycle.
REQ-017 SHALL give clear priority over start_stop and lap in the same cycle.
REQ-018 SHALL run the prescaler 0..TICK_DIV-1 only in RUN, hold it in PAUSE, and zero it in IDLE/HALT; width $clog2(TICK_DIV).
REQ-019 SHALL assert count_en combinationally when state==RUN and prescaler==TICK_DIV-1; the prescaler wraps to 0 that cycle.
REQ-020 SHALL, with STOP_AT_MAX=1, suppress count_en when chain_max=1 at a tick and enter HALT next cycle; with STOP_AT_MAX=0, chain_max is ignored.
REQ-021 SHALL keep resume phase: PAUSE->RUN continues from the held prescaler value.
REQ-022 SHALL, on start_stop in the same cycle as a tick, still emit that count_en, then pause.
REQ-023 SHALL drive running = (state==RUN) and overflow = (state==HALT).

Reset
REQ-024 SHALL, on reset_n=0 at a clk edge, set state IDLE, prescaler 0, and display_hold 0.
REQ-025 SHALL drive count_en 0, count_clr 0, running 0 and overflow 0 in the cycle after reset is sampled.
REQ-026 SHALL give reset priority over all inputs; reset mid-RUN SHALL lose prescaler phase.

Configuration
REQ-027 SHALL compile lap support in only when macro STOPWATCH_LAP_EN is defined.
REQ-028 SHALL, with STOPWATCH_LAP_EN, toggle display_hold on lap in RUN or PAUSE, ignore lap in IDLE/HALT, and clear display_hold on clear.
REQ-029 SHALL, without STOPWATCH_LAP_EN, ignore lap and tie display_hold to 0; the port SHALL remain.

Structure
REQ-030 SHALL take the state enum (IDLE/RUN/PAUSE/HALT) from shared package stopwatch_pkg.
REQ-031 SHALL implement the prescaler as sub-module tick_prescaler with inputs run and zero and output tick.

Verification (TICK_DIV=4)
REQ-032 SHALL check: reset, then start_stop at cycle 0 -> count_en pulses at cycles 4, 8, 12; running=1.
REQ-033 SHALL check: start_stop at cycle 6, then again at cycle 20 -> no count_en during 7..20; next count_en at cycle 22.
REQ-034 SHALL check: clear and start_stop in the same cycle while in RUN -> IDLE, count_clr=1 for one cycle, running=0.
REQ-035 SHALL check: STOP_AT_MAX=1, chain_max=1 at a tick -> count_en stays 0, overflow=1 next cycle, start_stop ignored, clear -> IDLE.
REQ-036 SHALL check: STOPWATCH_LAP_EN defined, lap in RUN -> display_hold=1 while count_en continues; lap again -> 0; undefined -> display_hold always 0.
REQ-037 SHALL check: reset_n=0 mid-RUN with prescaler=2 -> all outputs 0; after start_stop, first count_en 4 cycles later.
